pipelined_reduce_gate: RTL and testbench
========================================

Name: pipelined_reduce_gate

Overview:
Parametrised, pipelined N-input reduction gate: the registered, multi-mode successor of the fixed 8-input bubbled AND gate.
- Applies a per-input inversion ("bubble") mask, which is runtime-loadable, with a parameter giving its reset value.
- Reduces all inputs with AND/OR/XOR/NAND through a radix-R register tree, with valid tagging.
- Used in the processor datapath for wide flag and zero detection and for decode terms that must be registered to meet timing.

Parameters:
NR_OF_INPUTS, 8, number of 1-bit inputs; legal range 2..64.
BUBBLES_MASK, 0, NR_OF_INPUTS-bit reset value of the inversion mask; bit i set inverts input i.
RADIX, 4, fan-in per tree node; legal values 2 or 4.

Ports:
Clock  in  1  rising-edge clock.
Reset_n  in  1  asynchronous, active-low reset.
ClockEnable  in  1  global advance enable; when low, all state is frozen.
Inputs  in  NR_OF_INPUTS  operand bits; bit i is input i.
Valid_In  in  1  marks Inputs/Mode as a valid operand this cycle.
Mode  in  2  00=AND, 01=OR, 10=XOR, 11=NAND.
Mask_Load  in  1  loads Mask_Data into the mask register.
Mask_Data  in  NR_OF_INPUTS  new mask value.
Mask  out  NR_OF_INPUTS  current mask register (readback).
Result  out  1  last valid reduction result.
Valid_Out  out  1  one-cycle pulse when Result has just been updated.

Behaviour:
- Clocking: one clock. Reset is asynchronous and active-low; Reset_n low acts immediately, independent of Clock.
- Reset values: Mask=BUBBLES_MASK; Result=0; Valid_Out=0; all pipeline data and valid registers 0.
- Stage count L = ceil(log_RADIX(NR_OF_INPUTS)), minimum 1 (NR_OF_INPUTS=8, RADIX=4 gives L=2).
- Latency: an operand captured at edge t produces Result/Valid_Out at edge t+L. Throughput is one operand per cycle.
- Stage 1:
  - Computes Inputs XOR Mask using the Mask value from before any same-cycle load.
  - Pads missing leaves with the identity element: 1 for AND/NAND, 0 for OR/XOR.
  - Reduces groups of RADIX inputs.
- Stages 2..L: each reduces groups of RADIX partial results from the previous stage.
- Mode and Valid_In travel down the pipeline with the data. A Mode change between consecutive operands never affects operands already in flight.
- NAND is computed as AND throughout, then inverted at the final stage only.
- Output register:
  - When the final stage is valid, Result takes the reduced value and Valid_Out=1.
  - Otherwise Result holds its value and Valid_Out=0.
  - Valid_In=0 bubbles propagate as invalid slots.
- Mask_Load=1 with ClockEnable=1: Mask takes Mask_Data at that edge. The new mask applies to operands captured from the next edge on.
- ClockEnable=0: every register holds, including Mask (Mask_Load ignored), Result and Valid_Out. A Valid_Out already high stays high. Operands resume on re-enable with their cycle-count latency unchanged.
- Reset mid-operation: all in-flight operands are discarded, Valid_Out goes 0 immediately, Mask returns to BUBBLES_MASK.
- Illegal parameter values (NR_OF_INPUTS outside 2..64, RADIX not 2 or 4) are an elaboration error.

Optional Feature:
REDUCE_ONES_COUNT_EN.
- Defined: adds output Ones_Count [clog2(NR_OF_INPUTS+1)-1:0].
  - Counts the population of set bits in the masked inputs, independent of Mode.
  - Pipelined alongside the reduction with the same latency L.
  - Same hold, update and reset rules as Result (reset value 0).
- Not defined: the port and its adder tree are absent. All other behaviour is identical.

Decomposition:
- Package reduce_gate_pkg holds:
  - Mode encodings: MODE_AND, MODE_OR, MODE_XOR, MODE_NAND.
  - Function clog2.
  - Function nr_of_stages(n, radix).
  - Function identity_bit(mode).
- One sub-module, reduce_gate_stage: a single registered stage of radix-R reduction nodes.
  - Inputs: width and mode.
  - Carries the valid and mode registers and, under REDUCE_ONES_COUNT_EN, the partial counts.
  - The top level instantiates L of them via generate.

Test Plan:
1. Reset check, N=8, R=4, BUBBLES_MASK=8'h01 -> Mask=8'h01, Result=0, Valid_Out=0 during and after reset.
2. AND with mask 8'h01, Valid_In at edge t:
   - Inputs=8'hFE -> Result=1 and Valid_Out pulse at t+2.
   - Inputs=8'hFF -> Result=0.
3. Back-to-back operands, mask 0:
   - AND 8'hFF, then XOR 8'h07, then OR 8'h00, then NAND 8'hFF on consecutive edges.
   - -> Results 1,1,0,0 on four consecutive Valid_Out cycles.
4. Mask_Load with Mask_Data=8'hFF in the same cycle as AND, Inputs=8'h00, old mask 0 -> Result 0.
   - Same operand on the next cycle -> Result 1.
5. ClockEnable low for 3 cycles with two operands in flight -> Result/Valid_Out frozen; results appear 3 cycles later than nominal, in order.
6. Two padding/reset checks:
   - N=5, R=4, NAND, Inputs=5'h1F -> Result 0; OR with 5'h00 -> 0.
   - Reset_n pulsed low with an operand in flight -> no Valid_Out follows, Mask=BUBBLES_MASK.

Source files
------------

// File: rtl/reduce_gate_pkg.sv
// Shared definitions for the pipelined reduction gate: mode encodings and
// elaboration-time helpers for sizing the radix tree.
package reduce_gate_pkg;

  typedef enum logic [1:0] {
    MODE_AND  = 2'b00,
    MODE_OR   = 2'b01,
    MODE_XOR  = 2'b10,
    MODE_NAND = 2'b11
  } mode_e;

  function automatic int clog2(input int value);
    int result;
    int rest;
    result = 0;
    rest   = value - 1;
    while (rest > 0) begin
      result++;
      rest = rest >> 1;
    end
    return result;
  endfunction

  // Width of the partial-result vector after k tree levels.
  function automatic int stage_width(input int n, input int radix, input int k);
    int w;
    w = n;
    for (int i = 0; i < k; i++) w = (w + radix - 1) / radix;
    return w;
  endfunction

  function automatic int nr_of_stages(input int n, input int radix);
    int w;
    int s;
    w = n;
    s = 0;
    while (w > 1) begin
      w = (w + radix - 1) / radix;
      s++;
    end
    return (s < 1) ? 1 : s;
  endfunction

  function automatic logic identity_bit(input mode_e mode);
    return (mode == MODE_AND) || (mode == MODE_NAND);
  endfunction

endpackage

// File: rtl/reduce_gate_stage.sv
// One registered level of radix-R reduction nodes; valid, mode and (with
// REDUCE_ONES_COUNT_EN) the partial population counts travel alongside.
module reduce_gate_stage
  import reduce_gate_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int RADIX   = 4,
`ifdef REDUCE_ONES_COUNT_EN
  parameter int COUNT_W = 4,
`endif
  localparam int OUT_W  = (WIDTH + RADIX - 1) / RADIX
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     valid_in,
  input  mode_e                    mode_in,
  input  logic [WIDTH-1:0]         data_in,
`ifdef REDUCE_ONES_COUNT_EN
  input  logic [WIDTH*COUNT_W-1:0] count_in,
  output logic [OUT_W*COUNT_W-1:0] count_out,
`endif
  output logic                     valid_out,
  output mode_e                    mode_out,
  output logic [OUT_W-1:0]         data_out
);

  localparam int PAD_W = OUT_W * RADIX;

  logic [PAD_W-1:0] padded;
  logic [OUT_W-1:0] next_data;

  // Missing leaves take the identity element so they never change a group.
  always_comb begin
    padded              = {PAD_W{identity_bit(mode_in)}};
    padded[WIDTH-1:0]   = data_in;
    next_data           = '0;
    for (int g = 0; g < OUT_W; g++) begin
      case (mode_in)
        MODE_OR:  next_data[g] = |padded[g*RADIX +: RADIX];
        MODE_XOR: next_data[g] = ^padded[g*RADIX +: RADIX];
        default:  next_data[g] = &padded[g*RADIX +: RADIX];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      mode_out  <= MODE_AND;
      data_out  <= '0;
    end else if (en) begin
      valid_out <= valid_in;
      mode_out  <= mode_in;
      data_out  <= next_data;
    end
  end

`ifdef REDUCE_ONES_COUNT_EN
  logic [PAD_W*COUNT_W-1:0] count_pad;
  logic [OUT_W*COUNT_W-1:0] next_count;

  always_comb begin
    count_pad                    = '0;
    count_pad[WIDTH*COUNT_W-1:0] = count_in;
    next_count                   = '0;
    for (int g = 0; g < OUT_W; g++) begin
      for (int j = 0; j < RADIX; j++) begin
        next_count[g*COUNT_W +: COUNT_W] = next_count[g*COUNT_W +: COUNT_W]
                                         + count_pad[(g*RADIX+j)*COUNT_W +: COUNT_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_out <= '0;
    else if (en) count_out <= next_count;
  end
`endif

endmodule

// File: rtl/pipelined_reduce_gate.sv
// Pipelined N-input AND/OR/XOR/NAND reduction with a loadable bubble mask.
// Optional Ones_Count output is enabled by defining REDUCE_ONES_COUNT_EN.
module pipelined_reduce_gate
  import reduce_gate_pkg::*;
#(
  parameter int                      NR_OF_INPUTS = 8,
  parameter logic [NR_OF_INPUTS-1:0] BUBBLES_MASK = '0,
  parameter int                      RADIX        = 4
) (
  input  logic                    Clock,
  input  logic                    Reset_n,
  input  logic                    ClockEnable,
  input  logic [NR_OF_INPUTS-1:0] Inputs,
  input  logic                    Valid_In,
  input  logic [1:0]              Mode,
  input  logic                    Mask_Load,
  input  logic [NR_OF_INPUTS-1:0] Mask_Data,
  output logic [NR_OF_INPUTS-1:0] Mask,
  output logic                    Result,
`ifdef REDUCE_ONES_COUNT_EN
  output logic [clog2(NR_OF_INPUTS+1)-1:0] Ones_Count,
`endif
  output logic                    Valid_Out
);

  localparam int L = nr_of_stages(NR_OF_INPUTS, RADIX);
`ifdef REDUCE_ONES_COUNT_EN
  localparam int CW = clog2(NR_OF_INPUTS + 1);
`endif

  if (NR_OF_INPUTS < 2 || NR_OF_INPUTS > 64 || (RADIX != 2 && RADIX != 4)) begin : g_bad_params
    $error("pipelined_reduce_gate: NR_OF_INPUTS must be 2..64 and RADIX 2 or 4");
  end

  logic [NR_OF_INPUTS-1:0] masked;

  // A load takes effect at the edge, so the operand captured there still sees the old mask.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) Mask <= BUBBLES_MASK;
    else if (ClockEnable && Mask_Load) Mask <= Mask_Data;
  end

  assign masked = Inputs ^ Mask;

  for (genvar k = 0; k < L; k++) begin : g_stage
    localparam int IN_W  = stage_width(NR_OF_INPUTS, RADIX, k);
    localparam int OUT_W = stage_width(NR_OF_INPUTS, RADIX, k + 1);

    logic [IN_W-1:0]  data_in;
    logic             valid_in;
    mode_e            mode_in;
    logic [OUT_W-1:0] data_out;
    logic             valid_out;
    mode_e            mode_out;
`ifdef REDUCE_ONES_COUNT_EN
    logic [IN_W*CW-1:0]  count_in;
    logic [OUT_W*CW-1:0] count_out;
`endif

    if (k == 0) begin : g_head
      assign data_in  = masked;
      assign valid_in = Valid_In;
      assign mode_in  = mode_e'(Mode);
`ifdef REDUCE_ONES_COUNT_EN
      for (genvar b = 0; b < IN_W; b++) begin : g_leaf
        assign count_in[b*CW +: CW] = CW'(masked[b]);
      end
`endif
    end else begin : g_link
      assign data_in  = g_stage[k-1].data_out;
      assign valid_in = g_stage[k-1].valid_out;
      assign mode_in  = g_stage[k-1].mode_out;
`ifdef REDUCE_ONES_COUNT_EN
      assign count_in = g_stage[k-1].count_out;
`endif
    end

    reduce_gate_stage #(
      .WIDTH   (IN_W),
`ifdef REDUCE_ONES_COUNT_EN
      .COUNT_W (CW),
`endif
      .RADIX   (RADIX)
    ) u_stage (
      .clk       (Clock),
      .rst_n     (Reset_n),
      .en        (ClockEnable),
      .valid_in  (valid_in),
      .mode_in   (mode_in),
      .data_in   (data_in),
`ifdef REDUCE_ONES_COUNT_EN
      .count_in  (count_in),
      .count_out (count_out),
`endif
      .valid_out (valid_out),
      .mode_out  (mode_out),
      .data_out  (data_out)
    );
  end

  logic  final_data;
  logic  final_valid;
  mode_e final_mode;

  assign final_data  = g_stage[L-1].data_out[0];
  assign final_valid = g_stage[L-1].valid_out;
  assign final_mode  = g_stage[L-1].mode_out;

  // NAND rides the tree as AND; only here does it get its inversion.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Result    <= 1'b0;
      Valid_Out <= 1'b0;
    end else if (ClockEnable) begin
      Valid_Out <= final_valid;
      if (final_valid) Result <= (final_mode == MODE_NAND) ? ~final_data : final_data;
    end
  end

`ifdef REDUCE_ONES_COUNT_EN
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) Ones_Count <= '0;
    else if (ClockEnable && final_valid) Ones_Count <= g_stage[L-1].count_out;
  end
`endif

endmodule

// File: tb/tb_pipelined_reduce_gate.sv
// Self-checking bench for pipelined_reduce_gate: directed scenarios on two
// small configurations plus a randomized scoreboard run on a radix-2 build.
module tb_pipelined_reduce_gate;

  localparam logic [1:0] M_AND  = 2'd0;
  localparam logic [1:0] M_OR   = 2'd1;
  localparam logic [1:0] M_XOR  = 2'd2;
  localparam logic [1:0] M_NAND = 2'd3;
  // 13 inputs, radix 2: 13 -> 7 -> 4 -> 2 -> 1 gives four tree levels.
  localparam int C_LAT = 4;

  typedef struct {
    logic val;
    int   due;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n;
  logic clock_enable;

  logic [7:0]  a_inputs, a_mask_data, a_mask;
  logic [1:0]  a_mode;
  logic        a_valid_in, a_mask_load, a_result, a_valid_out;
  logic [4:0]  b_inputs, b_mask_data, b_mask;
  logic [1:0]  b_mode;
  logic        b_valid_in, b_mask_load, b_result, b_valid_out;
  logic [12:0] c_inputs, c_mask_data, c_mask;
  logic [1:0]  c_mode;
  logic        c_valid_in, c_mask_load, c_result, c_valid_out;
`ifdef REDUCE_ONES_COUNT_EN
  logic [3:0]  a_count, c_count;
  logic [2:0]  b_count;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  pipelined_reduce_gate #(.NR_OF_INPUTS(8), .BUBBLES_MASK(8'h01), .RADIX(4)) dut_a (
    .Clock(clock), .Reset_n(reset_n), .ClockEnable(clock_enable), .Inputs(a_inputs),
    .Valid_In(a_valid_in), .Mode(a_mode), .Mask_Load(a_mask_load), .Mask_Data(a_mask_data),
    .Mask(a_mask), .Result(a_result),
`ifdef REDUCE_ONES_COUNT_EN
    .Ones_Count(a_count),
`endif
    .Valid_Out(a_valid_out));

  pipelined_reduce_gate #(.NR_OF_INPUTS(5), .BUBBLES_MASK(5'h00), .RADIX(4)) dut_b (
    .Clock(clock), .Reset_n(reset_n), .ClockEnable(clock_enable), .Inputs(b_inputs),
    .Valid_In(b_valid_in), .Mode(b_mode), .Mask_Load(b_mask_load), .Mask_Data(b_mask_data),
    .Mask(b_mask), .Result(b_result),
`ifdef REDUCE_ONES_COUNT_EN
    .Ones_Count(b_count),
`endif
    .Valid_Out(b_valid_out));

  pipelined_reduce_gate #(.NR_OF_INPUTS(13), .BUBBLES_MASK(13'h0A5), .RADIX(2)) dut_c (
    .Clock(clock), .Reset_n(reset_n), .ClockEnable(clock_enable), .Inputs(c_inputs),
    .Valid_In(c_valid_in), .Mode(c_mode), .Mask_Load(c_mask_load), .Mask_Data(c_mask_data),
    .Mask(c_mask), .Result(c_result),
`ifdef REDUCE_ONES_COUNT_EN
    .Ones_Count(c_count),
`endif
    .Valid_Out(c_valid_out));

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_all;
    a_inputs = '0; a_valid_in = 1'b0; a_mode = M_AND; a_mask_load = 1'b0; a_mask_data = '0;
    b_inputs = '0; b_valid_in = 1'b0; b_mode = M_AND; b_mask_load = 1'b0; b_mask_data = '0;
    c_inputs = '0; c_valid_in = 1'b0; c_mode = M_AND; c_mask_load = 1'b0; c_mask_data = '0;
  endtask

  task automatic test_reset;
    clock_enable = 1'b1;
    idle_all();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) tick();
      if (i == 2) begin
        reset_n = 1'b1;
        tick();
      end
      tests_run++;
      if (a_mask !== 8'h01) begin
        tests_failed++; $display("[TB] FAIL reset_mask[%0d]: got %h expected 01", i, a_mask);
      end
      tests_run++;
      if (a_result !== 1'b0 || a_valid_out !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL reset_outputs[%0d]: got result=%b valid=%b expected 0/0", i, a_result, a_valid_out);
      end
    end
    tests_run++;
    if (b_mask !== 5'h00 || c_mask !== 13'h0A5) begin
      tests_failed++; $display("[TB] FAIL reset_mask_other: got %h/%h expected 00/0a5", b_mask, c_mask);
    end
  endtask

  task automatic test_and_mask;
    logic [7:0] ops [2];
    logic       exp_r [2];
    ops = '{8'hFE, 8'hFF};
    exp_r = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      a_valid_in = 1'b1; a_mode = M_AND; a_inputs = ops[i];
      tick();
      a_valid_in = 1'b0;
      tick();
      tests_run++;
      if (a_valid_out !== 1'b0) begin
        tests_failed++; $display("[TB] FAIL and_early[%0d]: got valid=%b expected 0", i, a_valid_out);
      end
      tick();
      tests_run++;
      if (a_valid_out !== 1'b1 || a_result !== exp_r[i]) begin
        tests_failed++;
        $display("[TB] FAIL and_mask[%0d]: got valid=%b result=%b expected 1/%b", i, a_valid_out, a_result, exp_r[i]);
      end
      tick();
      tests_run++;
      if (a_valid_out !== 1'b0) begin
        tests_failed++; $display("[TB] FAIL and_pulse[%0d]: got valid=%b expected 0", i, a_valid_out);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] modes [4];
    logic [7:0] ops [4];
    logic       exp_r [4];
    modes = '{M_AND, M_XOR, M_OR, M_NAND};
    ops = '{8'hFF, 8'h07, 8'h00, 8'hFF};
    exp_r = '{1'b1, 1'b1, 1'b0, 1'b0};
    a_mask_load = 1'b1; a_mask_data = 8'h00;
    tick();
    a_mask_load = 1'b0;
    tests_run++;
    if (a_mask !== 8'h00) begin
      tests_failed++; $display("[TB] FAIL b2b_mask_load: got %h expected 00", a_mask);
    end
    for (int i = 0; i < 7; i++) begin
      a_valid_in = (i < 4);
      if (i < 4) begin
        a_mode = modes[i]; a_inputs = ops[i];
      end
      tick();
      tests_run++;
      if (i >= 2 && i < 6) begin
        if (a_valid_out !== 1'b1 || a_result !== exp_r[i-2]) begin
          tests_failed++;
          $display("[TB] FAIL b2b[%0d]: got valid=%b result=%b expected 1/%b", i - 2, a_valid_out, a_result, exp_r[i-2]);
        end
      end else if (a_valid_out !== 1'b0) begin
        tests_failed++; $display("[TB] FAIL b2b_idle[%0d]: got valid=%b expected 0", i, a_valid_out);
      end
    end
  endtask

  task automatic test_mask_load;
    a_valid_in = 1'b1; a_mode = M_AND; a_inputs = 8'h00;
    a_mask_load = 1'b1; a_mask_data = 8'hFF;
    tick();
    a_mask_load = 1'b0;
    tests_run++;
    if (a_mask !== 8'hFF) begin
      tests_failed++; $display("[TB] FAIL mask_readback: got %h expected ff", a_mask);
    end
    tick();
    a_valid_in = 1'b0;
    tick();
    tests_run++;
    if (a_valid_out !== 1'b1 || a_result !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL mask_old: got valid=%b result=%b expected 1/0", a_valid_out, a_result);
    end
    tick();
    tests_run++;
    if (a_valid_out !== 1'b1 || a_result !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL mask_new: got valid=%b result=%b expected 1/1", a_valid_out, a_result);
    end
    tick();
  endtask

  task automatic test_clock_enable;
    // Mask is ff here: AND 01 reduces to 0, OR 00 reduces to 1.
    a_valid_in = 1'b1; a_mode = M_AND; a_inputs = 8'h01;
    tick();
    a_mode = M_OR; a_inputs = 8'h00;
    tick();
    clock_enable = 1'b0;
    a_mode = M_XOR; a_inputs = 8'h5A; a_mask_load = 1'b1; a_mask_data = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (a_valid_out !== 1'b0 || a_result !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL ce_freeze[%0d]: got valid=%b result=%b expected 0/1", i, a_valid_out, a_result);
      end
    end
    clock_enable = 1'b1;
    a_valid_in = 1'b0; a_mask_load = 1'b0;
    tick();
    tests_run++;
    if (a_valid_out !== 1'b1 || a_result !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL ce_first: got valid=%b result=%b expected 1/0", a_valid_out, a_result);
    end
    clock_enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests_run++;
      if (a_valid_out !== 1'b1 || a_result !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL ce_hold_high[%0d]: got valid=%b result=%b expected 1/0", i, a_valid_out, a_result);
      end
    end
    clock_enable = 1'b1;
    tick();
    tests_run++;
    if (a_valid_out !== 1'b1 || a_result !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL ce_second: got valid=%b result=%b expected 1/1", a_valid_out, a_result);
    end
    tick();
    tests_run++;
    if (a_valid_out !== 1'b0 || a_mask !== 8'hFF) begin
      tests_failed++; $display("[TB] FAIL ce_after: got valid=%b mask=%h expected 0/ff", a_valid_out, a_mask);
    end
  endtask

  task automatic test_padding;
    logic [1:0] modes [6];
    logic [4:0] ops [6];
    logic       exp_r [6];
    modes = '{M_NAND, M_OR, M_AND, M_XOR, M_AND, M_XOR};
    ops = '{5'h1F, 5'h00, 5'h1F, 5'h1F, 5'h0F, 5'h10};
    exp_r = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      b_valid_in = (i < 6);
      if (i < 6) begin
        b_mode = modes[i]; b_inputs = ops[i];
      end
      tick();
      if (i >= 2) begin
        tests_run++;
        if (b_valid_out !== 1'b1 || b_result !== exp_r[i-2]) begin
          tests_failed++;
          $display("[TB] FAIL pad5[%0d]: got valid=%b result=%b expected 1/%b", i - 2, b_valid_out, b_result, exp_r[i-2]);
        end
      end
    end
    b_valid_in = 1'b0;
    tick();
  endtask

  task automatic test_reset_midflight;
    a_valid_in = 1'b1; a_mode = M_AND; a_inputs = 8'h00;
    tick();
    a_mode = M_OR;
    tick();
    a_valid_in = 1'b0;
    tick();
    tests_run++;
    if (a_valid_out !== 1'b1 || a_result !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL pre_reset: got valid=%b result=%b expected 1/1", a_valid_out, a_result);
    end
    #1 reset_n = 1'b0;
    #1;
    tests_run++;
    if (a_valid_out !== 1'b0 || a_result !== 1'b0 || a_mask !== 8'h01) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: got valid=%b result=%b mask=%h expected 0/0/01", a_valid_out, a_result, a_mask);
    end
    #1 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if (a_valid_out !== 1'b0 || a_mask !== 8'h01) begin
        tests_failed++;
        $display("[TB] FAIL reset_discard[%0d]: got valid=%b mask=%h expected 0/01", i, a_valid_out, a_mask);
      end
    end
  endtask

  task automatic test_random;
    exp_t        sb[$];
    int          en_count = 0;
    logic [12:0] mask_model = 13'h0A5;
    logic [12:0] masked;
    logic        last_result = 1'b0;
    logic        last_valid = 1'b0;
    logic        expv, ce, vin, drain;
    for (int i = 0; i < 400; i++) begin
      drain = (i >= 390);
      ce  = drain ? 1'b1 : ($urandom_range(0, 5) != 0);
      vin = drain ? 1'b0 : ($urandom_range(0, 3) != 0);
      c_mode = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       c_inputs = ~mask_model;
        1:       c_inputs = mask_model;
        default: c_inputs = 13'($urandom);
      endcase
      c_mask_load = !drain && ($urandom_range(0, 15) == 0);
      c_mask_data = 13'($urandom);
      clock_enable = ce;
      c_valid_in = vin;
      masked = c_inputs ^ mask_model;
      case (c_mode)
        M_AND:   expv = (masked == 13'h1FFF);
        M_OR:    expv = (masked != 13'h0000);
        M_XOR:   expv = ($countones(masked) % 2 == 1);
        default: expv = (masked != 13'h1FFF);
      endcase
      tick();
      if (ce) begin
        en_count++;
        if (vin) sb.push_back('{expv, en_count + C_LAT});
        if (c_mask_load) mask_model = c_mask_data;
        tests_run++;
        if (sb.size() > 0 && sb[0].due == en_count) begin
          if (c_valid_out !== 1'b1 || c_result !== sb[0].val) begin
            tests_failed++;
            $display("[TB] FAIL rand_result[%0d]: got valid=%b result=%b expected 1/%b", i, c_valid_out, c_result, sb[0].val);
          end
          last_result = sb[0].val;
          last_valid = 1'b1;
          void'(sb.pop_front());
        end else begin
          if (c_valid_out !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL rand_idle[%0d]: got valid=%b expected 0", i, c_valid_out);
          end
          last_valid = 1'b0;
        end
      end else begin
        tests_run++;
        if (c_valid_out !== last_valid || c_result !== last_result) begin
          tests_failed++;
          $display("[TB] FAIL rand_hold[%0d]: got valid=%b result=%b expected %b/%b", i, c_valid_out, c_result, last_valid, last_result);
        end
      end
      tests_run++;
      if (c_mask !== mask_model) begin
        tests_failed++; $display("[TB] FAIL rand_mask[%0d]: got %h expected %h", i, c_mask, mask_model);
      end
    end
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++; $display("[TB] FAIL rand_drain: got %0d pending expected 0", sb.size());
    end
    idle_all();
  endtask

  initial begin
    test_reset();
    test_and_mask();
    test_back_to_back();
    test_mask_load();
    test_clock_enable();
    test_padding();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
